// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: execute-lane inputs and fetch flush handshake of branch_resolve_unit
//   lane_valid/op/data1/data2/bid/addr : per-lane resolving branch, lane i packed at slice i
//   oldest_bid  : bid of the oldest in-flight branch (age reference)
//   flush_ready : fetch accepts the pending flush this cycle
//   flush_valid/bid/addr : pending flush, flush_count : saturating count of accepted flushes
interface branch_resolve_unit_if #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BID_WIDTH  = 3,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_LANES-1:0]            lane_valid;
  logic [4*NUM_LANES-1:0]          lane_op;
  logic [DATA_WIDTH*NUM_LANES-1:0] lane_data1;
  logic [DATA_WIDTH*NUM_LANES-1:0] lane_data2;
  logic [BID_WIDTH*NUM_LANES-1:0]  lane_bid;
  logic [ADDR_WIDTH*NUM_LANES-1:0] lane_addr;
  logic [BID_WIDTH-1:0]            oldest_bid;
  logic                            flush_ready;
  logic                            flush_valid;
  logic [BID_WIDTH-1:0]            flush_bid;
  logic [ADDR_WIDTH-1:0]           flush_addr;
  logic [CNT_WIDTH-1:0]            flush_count;
  modport master (
    output lane_valid, lane_op, lane_data1, lane_data2, lane_bid, lane_addr, oldest_bid, flush_ready,
    input  flush_valid, flush_bid, flush_addr, flush_count
  );
  modport slave (
    input  lane_valid, lane_op, lane_data1, lane_data2, lane_bid, lane_addr, oldest_bid, flush_ready,
    output flush_valid, flush_bid, flush_addr, flush_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves up to NUM_LANES branches per cycle and holds the oldest redirect as a pending flush
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of branch_resolve_unit_if (lane inputs in, flush handshake and counter out)
module branch_resolve_unit #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BID_WIDTH  = 3,
  parameter int PIPE_CMP   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);
  logic [NUM_LANES-1:0]  w_redir;
  logic [NUM_LANES-1:0]  w_sel_v;
  logic [BID_WIDTH-1:0]  w_lane_bid  [NUM_LANES];
  logic [ADDR_WIDTH-1:0] w_lane_addr [NUM_LANES];
  logic [BID_WIDTH-1:0]  w_sel_bid   [NUM_LANES];
  logic [ADDR_WIDTH-1:0] w_sel_addr  [NUM_LANES];
  logic [BID_WIDTH-1:0]  w_age       [NUM_LANES];
  logic                  w_cand_v;
  logic [BID_WIDTH-1:0]  w_cand_bid;
  logic [BID_WIDTH-1:0]  w_cand_age;
  logic [ADDR_WIDTH-1:0] w_cand_addr;
  logic [BID_WIDTH-1:0]  w_pend_age;
  logic                  w_hs;
  logic                  w_load;
  logic                  r_flush_valid;
  logic [BID_WIDTH-1:0]  r_flush_bid;
  logic [ADDR_WIDTH-1:0] r_flush_addr;
  logic [CNT_WIDTH-1:0]  r_flush_count;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [3:0]            w_op;
    logic [DATA_WIDTH-1:0] w_d1;
    logic [DATA_WIDTH-1:0] w_d2;
    assign w_op           = bus.lane_op[4*i +: 4];
    assign w_d1           = bus.lane_data1[DATA_WIDTH*i +: DATA_WIDTH];
    assign w_d2           = bus.lane_data2[DATA_WIDTH*i +: DATA_WIDTH];
    assign w_lane_bid[i]  = bus.lane_bid[BID_WIDTH*i +: BID_WIDTH];
    assign w_lane_addr[i] = bus.lane_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
    assign w_redir[i] = bus.lane_valid[i] && (
      (w_op == 4'hA && w_d1 == w_d2) ||
      (w_op == 4'hB && w_d1 != w_d2) ||
      (w_op == 4'hC && $signed(w_d1) <  $signed(w_d2)) ||
      (w_op == 4'hD && $signed(w_d1) >= $signed(w_d2)));
    // age is taken against the oldest_bid present at selection time, even for registered lanes
    assign w_age[i] = w_sel_bid[i] - bus.oldest_bid;
  end
  if (PIPE_CMP != 0) begin : g_pipe
    logic [NUM_LANES-1:0]  r_v;
    logic [BID_WIDTH-1:0]  r_bid  [NUM_LANES];
    logic [ADDR_WIDTH-1:0] r_addr [NUM_LANES];
    always_ff @(posedge clk) begin
      r_v    <= rst_n ? w_redir : '0;
      r_bid  <= w_lane_bid;
      r_addr <= w_lane_addr;
    end
    assign w_sel_v    = r_v;
    assign w_sel_bid  = r_bid;
    assign w_sel_addr = r_addr;
  end else begin : g_comb
    assign w_sel_v    = w_redir;
    assign w_sel_bid  = w_lane_bid;
    assign w_sel_addr = w_lane_addr;
  end
  // strict < keeps the lowest lane index on equal ages
  always_comb begin
    w_cand_v    = 1'b0;
    w_cand_bid  = '0;
    w_cand_addr = '0;
    w_cand_age  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (w_sel_v[l] && (!w_cand_v || w_age[l] < w_cand_age)) begin
        w_cand_v    = 1'b1;
        w_cand_bid  = w_sel_bid[l];
        w_cand_addr = w_sel_addr[l];
        w_cand_age  = w_age[l];
      end
    end
  end
  assign w_pend_age = r_flush_bid - bus.oldest_bid;
  assign w_hs       = r_flush_valid && bus.flush_ready;
  // a candidate is taken into an empty slot, or over the pending flush (accepted or not) only when strictly older
  assign w_load     = w_cand_v && (!r_flush_valid || w_cand_age < w_pend_age);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flush_valid <= 1'b0;
      r_flush_bid   <= '0;
      r_flush_addr  <= '0;
      r_flush_count <= '0;
    end else begin
      r_flush_valid <= w_load || (r_flush_valid && !w_hs);
      if (w_load) begin
        r_flush_bid  <= w_cand_bid;
        r_flush_addr <= w_cand_addr;
      end
      if (w_hs && r_flush_count != '1) r_flush_count <= r_flush_count + 1'b1;
    end
  end
  assign bus.flush_valid = r_flush_valid;
  assign bus.flush_bid   = r_flush_bid;
  assign bus.flush_addr  = r_flush_addr;
  assign bus.flush_count = r_flush_count;
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch resolution unit; successor to the fixed 4-lane combinational branch control.
- Evaluates up to NUM_LANES resolving branches per cycle and selects the oldest redirecting branch by circular bid age.
- Holds that branch as a pending flush until fetch accepts it with a valid/ready handshake.
- Sits between the execute-stage branch lanes and fetch/rename flush logic.

Parameters:
NUM_LANES, 4, number of branch resolution lanes
DATA_WIDTH, 32, operand width
ADDR_WIDTH, 5, branch target address width
BID_WIDTH, 3, branch id width; ids wrap modulo 2^BID_WIDTH
PIPE_CMP, 1, 1 = register compare results before selection; 0 = compare and select in one cycle
CNT_WIDTH, 16, width of the flush statistics counter

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
lane_valid  input  NUM_LANES  bit i = lane i holds a resolving branch
lane_op  input  4*NUM_LANES  op of lane i at [4i+3:4i]
lane_data1  input  DATA_WIDTH*NUM_LANES  first operand per lane
lane_data2  input  DATA_WIDTH*NUM_LANES  second operand per lane
lane_bid  input  BID_WIDTH*NUM_LANES  branch id per lane
lane_addr  input  ADDR_WIDTH*NUM_LANES  redirect address per lane
oldest_bid  input  BID_WIDTH  bid of oldest in-flight branch
flush_ready  input  1  fetch accepts the flush this cycle
flush_valid  output  1  pending flush present
flush_bid  output  BID_WIDTH  bid of the pending flush
flush_addr  output  ADDR_WIDTH  redirect address of the pending flush
flush_count  output  CNT_WIDTH  saturating count of accepted flushes

Behaviour:
- Reset is synchronous: when rst_n=0 at a clk edge, the compare pipeline valid bits, flush_valid, flush_bid, flush_addr and flush_count all go to 0. Reset mid-handshake drops the pending flush and does not count it.
- Ops: BEQ=4'hA redirects if data1==data2; BNE=4'hB if data1!=data2; BLT=4'hC if $signed(data1)<$signed(data2); BGE=4'hD if $signed(data1)>=$signed(data2). Any other op, or lane_valid=0, never redirects.
- Age = (bid - oldest_bid) mod 2^BID_WIDTH, unsigned. A smaller age is older.
- Age is always recomputed from the current oldest_bid, for both pending and incoming branches. In PIPE_CMP=1 mode, the age of incoming branches uses oldest_bid at selection time.
- PIPE_CMP=1 stage:
  - Per-lane redirect flag, bid and addr are registered at edge t.
  - Selection and pending update happen at edge t+1.
  - flush_valid is first visible in the cycle after edge t+1 (2-cycle latency from inputs).
- PIPE_CMP=0: selection happens at edge t; 1-cycle latency.
- Candidate = redirecting lane with minimum age. Equal ages are broken by the lowest lane index.
- Pending register update, per edge (a = handshake, flush_valid && flush_ready):
  - No pending, candidate present: load the candidate.
  - Pending, no a, candidate strictly older than pending: replace the pending flush. flush_bid and flush_addr may change while flush_valid stays high.
  - Pending, no a, candidate not strictly older: keep the pending flush and drop the candidate (it is wrong-path).
  - a, candidate strictly older than the accepted flush: load the candidate, so flush_valid stays 1.
  - a, otherwise: clear flush_valid and drop the candidate.
- flush_count increments on each a and saturates at 2^CNT_WIDTH-1.
- Outputs are driven from registers only; there is no combinational path from lane inputs to outputs.
- The compare pipeline never stalls. flush_ready affects only the pending register.

Test Plan:
- Defaults, PIPE_CMP=1, flush_ready=1, oldest_bid=0. Edge t drives lane1 BEQ 5,5 bid=2 addr=9. Required: flush_valid=1 after edge t+1 with flush_bid=2 and flush_addr=9; flush_count=1 after edge t+2; flush_valid=0 after edge t+2 if no further candidate.
- Same cycle, lane0 BNE 3,3 (no redirect), lane2 BLT -1,0 bid=4 addr=7, lane3 BGE 0,-1 bid=1 addr=6, oldest_bid=0. Required: flush_bid=1, flush_addr=6.
- Wrap-around: oldest_bid=6; lane0 redirects with bid=1, lane1 redirects with bid=7. Required: bid 7 (age 1) is chosen over bid 1 (age 3).
- flush_ready=0 with pending bid=5, oldest_bid=0:
  - Redirect bid=3 arrives: pending becomes bid 3.
  - Redirect bid=6 then arrives: ignored.
  - Raise flush_ready: one handshake with bid 3; flush_count=1.
- Accept with a simultaneous older candidate: pending bid=4 is accepted in the same cycle a candidate bid=2 is selected. Required: flush_valid stays 1 with bid 2. A younger candidate (bid=6) in that situation is dropped and flush_valid goes to 0.
- rst_n=0 for one edge while a flush is pending and the pipeline is full. Required: all outputs 0 next cycle, no handshake, flush_count=0. Separately, force the count to saturation and check it holds at all-ones.
